lcd_timing_800_480: RTL and testbench

- Raster timing generator for the 800x480 parallel-RGB LCD on the Tang Primer 20K dock.
- Runs on the pixel clock produced by the board PLL (32 MHz divided output → ~62 Hz refresh).
- Produces hsync, vsync and de, plus pixel coordinates, for the user graphics logic and the LCD pins.
- A pix_en strobe lets the block run from a faster clock at a fractional pixel rate.

---
 rtl/lcd_timing_800_480.sv | 137 +++++++++++++
 tb/tb_lcd_timing_800_480.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_800_480.sv
// lcd_timing_800_480
// Raster timing generator for an 800x480 parallel-RGB LCD panel.
// A free-running horizontal/vertical counter pair is advanced by pix_en_i,
// and every output is a registered decode of the counters as they stood
// at the pix_en_i edge. A pixel (h,v) therefore shows on the outputs one
// clock after the strobe that sampled it.
//
// Ports:
//   clk_i          pixel-domain clock
//   rst_i          synchronous active-high reset
//   pix_en_i       pixel advance strobe (tie high for one pixel per clock)
//   hsync_o        horizontal sync, active level HSYNC_POL
//   vsync_o        vertical sync, active level VSYNC_POL
//   de_o           data enable, high inside the active area only
//   x_o            horizontal position, counts through blanking
//   y_o            vertical position, counts through blanking
//   frame_start_o  one-clock pulse when pixel (0,0) is presented
//   line_start_o   one-clock pulse when x==0 is presented
module lcd_timing_800_480 #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 48,
  parameter int H_BACK    = 88,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 13,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 32,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pix_en_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_start_o,
  output logic          line_start_o
);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

  // Window edges as 32-bit values so an end bound equal to the total
  // (zero back porch) cannot wrap when narrowed to the counter width.
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FRONT);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FRONT);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [31:0] H_ACT  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT  = 32'(V_ACTIVE);

  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          fs_q, fs_d;
  logic          ls_q, ls_d;

  logic [31:0] h_ext, v_ext;
  logic        h_in_sync, v_in_sync;

  assign h_ext     = 32'(h_q);
  assign v_ext     = 32'(v_q);
  assign h_in_sync = (h_ext >= HS_BEG) && (h_ext < HS_END);
  assign v_in_sync = (v_ext >= VS_BEG) && (v_ext < VS_END);

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    x_d     = x_q;
    y_d     = y_q;
    de_d    = de_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    // Start strobes are single-clock pulses whatever the pix_en duty.
    fs_d    = 1'b0;
    ls_d    = 1'b0;
    if (pix_en_i) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      x_d     = h_q;
      y_d     = v_q;
      de_d    = (h_ext < H_ACT) && (v_ext < V_ACT);
      hsync_d = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
      ls_d    = (h_q == '0);
      fs_d    = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = fs_q;
  assign line_start_o  = ls_q;

endmodule

// File: tb/tb_lcd_timing_800_480.sv
module tb_lcd_timing_800_480;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    bit hp; bit vp;
  } tim_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic de; logic hs; logic vs; logic fs; logic ls;
  } out_t;

  typedef struct packed {
    bit   rst;
    bit   en;
    out_t e;
  } vec_t;

  localparam int XW0 = $clog2(976);
  localparam int YW0 = $clog2(528);
  localparam int XW1 = $clog2(15);
  localparam int YW1 = $clog2(8);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  logic           hs0, vs0, de0, fs0, ls0;
  logic [XW0-1:0] x0;
  logic [YW0-1:0] y0;
  logic           hs1, vs1, de1, fs1, ls1;
  logic [XW1-1:0] x1;
  logic [YW1-1:0] y1;
  logic           hs2, vs2, de2, fs2, ls2;
  logic [XW1-1:0] x2;
  logic [YW1-1:0] y2;

  lcd_timing_800_480 u_def (
    .clk_i(clk), .rst_i(rst), .pix_en_i(pix_en),
    .hsync_o(hs0), .vsync_o(vs0), .de_o(de0), .x_o(x0), .y_o(y0),
    .frame_start_o(fs0), .line_start_o(ls0));

  lcd_timing_800_480 #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_small (
    .clk_i(clk), .rst_i(rst), .pix_en_i(pix_en),
    .hsync_o(hs1), .vsync_o(vs1), .de_o(de1), .x_o(x1), .y_o(y1),
    .frame_start_o(fs1), .line_start_o(ls1));

  lcd_timing_800_480 #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_pol (
    .clk_i(clk), .rst_i(rst), .pix_en_i(pix_en),
    .hsync_o(hs2), .vsync_o(vs2), .de_o(de2), .x_o(x2), .y_o(y2),
    .frame_start_o(fs2), .line_start_o(ls2));

  int     n_cmp = 0;
  int     n_err = 0;
  tim_t   cfg [3];
  out_t   exp_o [3];
  longint pcnt = 0;

  // Reference: the n-th pixel strobe since reset is pixel index n of an
  // endless raster; position and regions follow by division and compare.
  function automatic out_t decode(tim_t t, longint p);
    out_t o;
    int ht, vt, h, v;
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    h  = int'(p % ht);
    v  = int'((p / ht) % vt);
    o.x  = 16'(h);
    o.y  = 16'(v);
    o.de = (h < t.ha) && (v < t.va);
    o.hs = ((h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs)) ? t.hp : !t.hp;
    o.vs = ((v >= t.va + t.vf) && (v < t.va + t.vf + t.vs)) ? t.vp : !t.vp;
    o.fs = (h == 0) && (v == 0);
    o.ls = (h == 0);
    return o;
  endfunction

  function automatic out_t reset_val(tim_t t);
    out_t o;
    o.x = 16'd0; o.y = 16'd0; o.de = 1'b0;
    o.hs = !t.hp; o.vs = !t.vp; o.fs = 1'b0; o.ls = 1'b0;
    return o;
  endfunction

  function automatic out_t get_act(int i);
    out_t o;
    case (i)
      0: begin o.x = 16'(x0); o.y = 16'(y0); o.de = de0; o.hs = hs0; o.vs = vs0; o.fs = fs0; o.ls = ls0; end
      1: begin o.x = 16'(x1); o.y = 16'(y1); o.de = de1; o.hs = hs1; o.vs = vs1; o.fs = fs1; o.ls = ls1; end
      default: begin o.x = 16'(x2); o.y = 16'(y2); o.de = de2; o.hs = hs2; o.vs = vs2; o.fs = fs2; o.ls = ls2; end
    endcase
    return o;
  endfunction

  task automatic chk_out(input string nm, input out_t a, input out_t e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s t=%0t: got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b ls=%b, want x=%0d y=%0d de=%b hs=%b vs=%b fs=%b ls=%b",
               nm, $time, a.x, a.y, a.de, a.hs, a.vs, a.fs, a.ls,
               e.x, e.y, e.de, e.hs, e.vs, e.fs, e.ls);
    end
  endtask

  task automatic chk(input string nm, input longint a, input longint e);
    n_cmp++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare all three instances just after the edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) exp_o[i] = reset_val(cfg[i]);
      else if (pix_en) exp_o[i] = decode(cfg[i], pcnt);
      else begin exp_o[i].fs = 1'b0; exp_o[i].ls = 1'b0; end
    end
    if (rst) pcnt = 0;
    else if (pix_en) pcnt++;
    #1;
    chk_out("model_def",   get_act(0), exp_o[0]);
    chk_out("model_small", get_act(1), exp_o[1]);
    chk_out("model_pol",   get_act(2), exp_o[2]);
  endtask

  function automatic vec_t mk(bit r, bit en, int x, int y, bit de, bit fs, bit ls);
    vec_t v;
    v.rst = r; v.en = en;
    v.e.x = 16'(x); v.e.y = 16'(y); v.e.de = de;
    v.e.hs = 1'b1; v.e.vs = 1'b1; v.e.fs = fs; v.e.ls = ls;
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    int de_cnt, hs_cnt, hs_cnt_l0, hs_first_x, ls_cnt, ls_first, ls_second;
    int fs_idx [$];
    int vs_low;
    int guard;
    bit found;

    cfg[0] = '{ha:800, hf:40, hs:48, hb:88, va:480, vf:13, vs:3, vb:32, hp:1'b0, vp:1'b0};
    cfg[1] = '{ha:8, hf:2, hs:3, hb:2, va:4, vf:1, vs:2, vb:1, hp:1'b0, vp:1'b0};
    cfg[2] = '{ha:8, hf:2, hs:3, hb:2, va:4, vf:1, vs:2, vb:1, hp:1'b1, vp:1'b1};

    // Directed vectors for the small raster (syncs inactive high here).
    tbl[0] = mk(1, 1, 0, 0, 0, 0, 0);   // rst wins over pix_en
    tbl[1] = mk(0, 1, 0, 0, 1, 1, 1);   // first pixel after reset
    tbl[2] = mk(0, 1, 1, 0, 1, 0, 0);
    tbl[3] = mk(0, 0, 1, 0, 1, 0, 0);   // hold without strobe
    tbl[4] = mk(0, 0, 1, 0, 1, 0, 0);
    tbl[5] = mk(0, 1, 2, 0, 1, 0, 0);
    tbl[6] = mk(1, 1, 0, 0, 0, 0, 0);   // mid-line reset
    tbl[7] = mk(0, 0, 0, 0, 0, 0, 0);   // reset state held while idle
    tbl[8] = mk(0, 1, 0, 0, 1, 1, 1);   // restart at (0,0)

    // Reset phase, with pix_en high to show reset dominance.
    rst = 1'b1; pix_en = 1'b1;
    repeat (3) tick();
    chk("pol_hsync_idle", hs2, 0);
    chk("pol_vsync_idle", vs2, 0);
    chk("def_hsync_idle", hs0, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; pix_en = tbl[i].en;
      tick();
      chk_out($sformatf("table_%0d", i), get_act(1), tbl[i].e);
    end

    // Two full lines on the default raster at one pixel per clock.
    rst = 1'b1; pix_en = 1'b1; tick();
    rst = 1'b0;
    de_cnt = 0; hs_cnt = 0; hs_cnt_l0 = 0; hs_first_x = -1;
    ls_cnt = 0; ls_first = -1; ls_second = -1;
    for (int k = 0; k < 2 * 976; k++) begin
      tick();
      if (de0) de_cnt++;
      if (!hs0) begin
        hs_cnt++;
        if (k < 976) hs_cnt_l0++;
        if (hs_first_x < 0) hs_first_x = int'(x0);
      end
      if (ls0) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = k;
        else if (ls_second < 0) ls_second = k;
      end
    end
    chk("de_clks_2lines", de_cnt, 1600);
    chk("hsync_low_line0", hs_cnt_l0, 48);
    chk("hsync_low_2lines", hs_cnt, 96);
    chk("hsync_first_x", hs_first_x, 840);
    chk("line_start_count", ls_cnt, 2);
    chk("line_start_period", ls_second - ls_first, 976);

    // Reset asserted while the default raster shows x=500 on line 2.
    found = 1'b0;
    guard = 0;
    while (!found && guard < 2000) begin
      tick();
      guard++;
      if (x0 == 500 && y0 == 2) found = 1'b1;
    end
    chk("reach_x500", found, 1);
    rst = 1'b1; tick();
    chk("midrst_x", x0, 0);
    chk("midrst_de", de0, 0);
    chk("midrst_hsync", hs0, 1);
    chk("midrst_fs", fs0, 0);
    rst = 1'b0; tick();
    chk("after_rst_fs", fs0, 1);
    chk("after_rst_ls", ls0, 1);
    chk("after_rst_xy", {x0, y0}, 0);
    chk("after_rst_de", de0, 1);

    // Small raster full frames: frame period and vsync width.
    rst = 1'b1; tick(); rst = 1'b0;
    fs_idx.delete(); vs_low = 0;
    for (int k = 0; k < 250; k++) begin
      tick();
      if (fs1) fs_idx.push_back(k);
      if (k < 240 && !vs1) vs_low++;
    end
    chk("small_fs_count", fs_idx.size(), 3);
    if (fs_idx.size() >= 2) chk("small_fs_period", fs_idx[1] - fs_idx[0], 120);
    chk("small_vsync_low", vs_low, 60);

    // One strobe every third clock: periods triple, pulses stay 1 wide.
    rst = 1'b1; tick(); rst = 1'b0;
    fs_idx.delete();
    for (int k = 0; k < 3 * 130; k++) begin
      pix_en = (k % 3 == 0);
      tick();
      if (fs1) fs_idx.push_back(k);
    end
    if (fs_idx.size() >= 2) chk("div3_fs_period", fs_idx[1] - fs_idx[0], 360);
    else chk("div3_fs_count", fs_idx.size(), 2);

    // Randomized strobes and rare resets against the reference model.
    for (int k = 0; k < 30000; k++) begin
      rst = ($urandom_range(0, 1499) == 0);
      case ((k / 5000) % 3)
        0: pix_en = ($urandom_range(0, 2) == 0);
        1: pix_en = $urandom_range(0, 1);
        default: pix_en = ($urandom_range(0, 7) != 0);
      endcase
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
